// File: rtl/sort_pkg.sv
// Shared types and compare helpers for the 4-word sort datapath.
package sort_pkg;

    typedef logic [31:0] data_t;

    localparam int SORT_N = 4;

    typedef data_t group_t [SORT_N];

    function automatic data_t min_u(input data_t a, input data_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic data_t max_u(input data_t a, input data_t b);
        return (a < b) ? b : a;
    endfunction

endpackage

// File: rtl/sort4_net.sv
// Combinational 4-word ascending sorter: five unsigned compare-exchanges in three levels.
module sort4_net
    import sort_pkg::*;
(
    input  group_t i_data,
    output group_t o_data
);

    group_t w_l1;
    group_t w_l2;

    assign w_l1[0] = min_u(i_data[0], i_data[1]);
    assign w_l1[1] = max_u(i_data[0], i_data[1]);
    assign w_l1[2] = min_u(i_data[2], i_data[3]);
    assign w_l1[3] = max_u(i_data[2], i_data[3]);

    assign w_l2[0] = min_u(w_l1[0], w_l1[2]);
    assign w_l2[2] = max_u(w_l1[0], w_l1[2]);
    assign w_l2[1] = min_u(w_l1[1], w_l1[3]);
    assign w_l2[3] = max_u(w_l1[1], w_l1[3]);

    // Outer words are final after level two; only the middle pair needs one more swap.
    assign o_data[0] = w_l2[0];
    assign o_data[1] = min_u(w_l2[1], w_l2[2]);
    assign o_data[2] = max_u(w_l2[1], w_l2[2]);
    assign o_data[3] = w_l2[3];

endmodule

// File: rtl/sort4_sched.sv
// Round-robin arbiter sharing one sort4_net between NREQ requesters, with a
// capture stage (S1), a registered sorted output stage (S2) and a handshake counter.
module sort4_sched
    import sort_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    input  group_t          req_data [NREQ],
    output logic [NREQ-1:0] req_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output group_t          out_data,
    output logic [ID_W-1:0] out_id,
    output logic [15:0]     done_cnt
);

    logic            r_s1_valid;
    group_t          r_s1_data;
    logic [ID_W-1:0] r_s1_id;
    logic [ID_W-1:0] r_ptr;

    logic            r_out_valid;
    group_t          r_out_data;
    logic [ID_W-1:0] r_out_id;
    logic [15:0]     r_done_cnt;

    group_t          w_sorted;
    logic            w_s2_load;
    logic            w_s1_free;
    logic            w_found;
    logic            w_accept;
    logic [ID_W-1:0] w_grant_id;
    logic [ID_W-1:0] w_idx;

    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
    assign w_s1_free = !r_s1_valid || w_s2_load;

    // Scan starts just after the last winner, so the winner gets lowest priority next.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_idx      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = ID_W'((32'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx;
            end
        end
    end

    assign w_accept = rst_n && w_found && w_s1_free;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '{default: '0};
            r_s1_id    <= '0;
            r_ptr      <= ID_W'(NREQ - 1);
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= req_data[w_grant_id];
                r_s1_id    <= w_grant_id;
                r_ptr      <= w_grant_id;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    sort4_net u_sort4_net (
        .i_data (r_s1_data),
        .o_data (w_sorted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '{default: '0};
            r_out_id    <= '0;
        end else begin
            if (w_s2_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sorted;
                r_out_id    <= r_s1_id;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_sort4_sched.sv
// Scoreboard bench for sort4_sched: occupancy/round-robin reference model plus sorted-queue checker.
module tb_sort4_sched;
    import sort_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned ID_W = $clog2(NREQ);

    typedef struct packed {
        logic [127:0]    d;
        logic [ID_W-1:0] id;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    group_t          req_data [NREQ];
    logic            out_valid;
    logic            out_ready = 1'b0;
    group_t          out_data;
    logic [ID_W-1:0] out_id;
    logic [15:0]     done_cnt;

    int checks = 0;
    int errors = 0;

    exp_t            exp_q[$];
    int              n_m = 0;
    bit              last_acc = 1'b0;
    int              ptr_m = NREQ - 1;
    logic [NREQ-1:0] acc_last = '0;
    int              acc_cnt = 0;
    int              hs_total = 0;
    bit              rec_ids = 1'b0;
    int              hs_ids[$];
    int              hs_cyc[$];
    int              cyc = 0;

    sort4_sched #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .done_cnt  (done_cnt)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [127:0] pack(input group_t g);
        return {g[3], g[2], g[1], g[0]};
    endfunction

    function automatic logic [127:0] model_sort(input group_t g);
        data_t q[$];
        for (int i = 0; i < SORT_N; i++) q.push_back(g[i]);
        q.sort();
        return {q[3], q[2], q[1], q[0]};
    endfunction

    // Reference: at most two groups in flight; a group is visible one edge after acceptance.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        bit              hs;
        bit              found;
        int              gid;
        int              idx;
        exp_t            e;
        if (!rst_n) begin
            chk("rst_req_ready", 192'(req_ready), 192'(0));
            chk("rst_out_valid", 192'(out_valid), 192'(0));
            chk("rst_done_cnt", 192'(done_cnt), 192'(0));
            n_m      = 0;
            last_acc = 1'b0;
            ptr_m    = NREQ - 1;
            acc_last = '0;
        end else begin
            hs = (n_m > int'(last_acc)) && out_ready;
            chk("out_valid", 192'(out_valid), 192'(n_m > int'(last_acc)));
            found = 1'b0;
            gid   = 0;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (ptr_m + k) % NREQ;
                if (!found && ((req_valid >> idx) & NREQ'(1)) != 0) begin
                    found = 1'b1;
                    gid   = idx;
                end
            end
            exp_rdy = '0;
            if (found && (n_m < 2 || out_ready)) exp_rdy = NREQ'(1) << gid;
            chk("req_ready", 192'(req_ready), 192'(exp_rdy));
            acc_last = req_valid & req_ready;
            if (exp_rdy != 0) begin
                e.d  = model_sort(req_data[gid]);
                e.id = ID_W'(gid);
                exp_q.push_back(e);
                ptr_m = gid;
                acc_cnt++;
            end
            n_m      = n_m + ((exp_rdy != 0) ? 1 : 0) - (hs ? 1 : 0);
            last_acc = (exp_rdy != 0);
        end
    end

    // Output monitor: pops the scoreboard on each handshake, checks hold and counter.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        exp_t hold_val;
        bit   hold_pend;
        if (!rst_n) begin
            exp_q.delete();
            hs_total  = 0;
            hold_pend = 1'b0;
        end else begin
            chk("done_cnt", 192'(done_cnt), 192'(hs_total[15:0]));
            got.d  = pack(out_data);
            got.id = out_id;
            if (hold_pend) chk("out_hold", 192'({out_valid, got}), 192'({1'b1, hold_val}));
            hold_pend = out_valid && !out_ready;
            hold_val  = got;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty got %0h want none", got);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_group", 192'(got), 192'(e));
                end
                hs_total++;
                if (rec_ids) begin
                    hs_ids.push_back(int'(out_id));
                    hs_cyc.push_back(cyc);
                end
            end
        end
    end

    // Requesters must hold valid and data until accepted.
    always @(negedge clk) begin
        logic [NREQ-1:0] prev_pend;
        logic [127:0]    prev_data [NREQ];
        if (!rst_n) begin
            prev_pend = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (((prev_pend >> i) & NREQ'(1)) != 0) begin
                    chk("req_hold", 192'({((req_valid >> i) & NREQ'(1)) != 0, pack(req_data[i])}),
                        192'({1'b1, prev_data[i]}));
                end
            end
            prev_pend = req_valid & ~req_ready;
            for (int i = 0; i < NREQ; i++) prev_data[i] = pack(req_data[i]);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic data_t rand_word();
        case ($urandom_range(3))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return data_t'($urandom_range(7));
            default: return data_t'($urandom);
        endcase
    endfunction

    task automatic refresh(input int pct);
        logic [NREQ-1:0] m;
        for (int i = 0; i < NREQ; i++) begin
            m = NREQ'(1) << i;
            if ((acc_last & m) != 0) req_valid = req_valid & ~m;
            if ((req_valid & m) == 0 && int'($urandom_range(99)) < pct) begin
                req_valid = req_valid | m;
                for (int k = 0; k < SORT_N; k++) req_data[i][k] = rand_word();
            end
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bit ok;
        ok        = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cycle();
            req_valid = req_valid & ~acc_last;
            if (req_valid == 0 && n_m == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_done", 192'(ok), 192'(1));
    endtask

    task automatic wait_acc(input int i);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (((acc_last >> i) & NREQ'(1)) != 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_wait", 192'(ok), 192'(1));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

    initial begin
        bit            done;
        logic [127:0]  snap;
        for (int i = 0; i < NREQ; i++) req_data[i] = '{default: '0};

        // Reset: requests must be ignored while rst_n is low.
        req_valid = '1;
        cycle();
        cycle();
        cycle();
        req_valid = '0;
        rst_n     = 1'b1;

        // Single group.
        req_valid   = 2'b01;
        req_data[0] = '{32'd9, 32'd3, 32'd7, 32'd1};
        out_ready   = 1'b1;
        @(negedge clk);
        chk("single_ready", 192'(req_ready), 192'(2'b01));
        cycle();
        req_valid = '0;
        cycle();
        @(negedge clk);
        chk("single_out", 192'({out_valid, pack(out_data), out_id}),
            192'({1'b1, 32'd9, 32'd7, 32'd3, 32'd1, 1'b0}));
        cycle();
        @(negedge clk);
        chk("single_cnt", 192'(done_cnt), 192'(1));
        cycle();

        // Fairness from reset.
        do_reset();
        out_ready = 1'b1;
        hs_ids.delete();
        hs_cyc.delete();
        rec_ids = 1'b1;
        refresh(100);
        for (int c = 0; c < 30; c++) begin
            cycle();
            refresh(100);
            if (hs_ids.size() >= 6) break;
        end
        rec_ids = 1'b0;
        if (hs_ids.size() >= 6) begin
            for (int j = 0; j < 6; j++) chk("fair_id", 192'(hs_ids[j]), 192'(j % 2));
            for (int j = 1; j < 6; j++) chk("fair_gap", 192'(hs_cyc[j] - hs_cyc[j-1]), 192'(1));
        end else begin
            chk("fair_count", 192'(hs_ids.size()), 192'(6));
        end
        drain();

        // Backpressure: two groups fill S1/S2, then everything stalls.
        out_ready = 1'b0;
        acc_cnt   = 0;
        refresh(100);
        repeat (5) begin
            cycle();
            refresh(100);
        end
        chk("bp_accepts", 192'(acc_cnt), 192'(2));
        @(negedge clk);
        chk("bp_ready_low", 192'(req_ready), 192'(0));
        snap = pack(out_data);
        cycle();
        @(negedge clk);
        chk("bp_stable", 192'(pack(out_data)), 192'(snap));
        drain();

        // Duplicates/extremes, then an already-sorted group.
        req_valid   = 2'b01;
        req_data[0] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};
        wait_acc(0);
        req_data[0] = '{32'd5, 32'd5, 32'd6, 32'd7};
        wait_acc(0);
        req_valid = '0;
        @(negedge clk);
        chk("dup_extreme", 192'(pack(out_data)), 192'({32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0}));
        cycle();
        @(negedge clk);
        chk("presorted", 192'(pack(out_data)), 192'({32'd7, 32'd6, 32'd5, 32'd5}));
        drain();

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        refresh(100);
        for (int c = 0; c < 10; c++) begin
            cycle();
            refresh(100);
            if (n_m == 2) break;
        end
        chk("mid_full", 192'(n_m), 192'(2));
        #2;
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_rst_out", 192'({out_valid, pack(out_data), out_id, done_cnt}), 192'(0));
        cycle();
        cycle();
        req_valid = '1;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < SORT_N; k++) req_data[i][k] = rand_word();
        out_ready = 1'b1;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("post_rst_prio", 192'(req_ready), 192'(2'b01));

        // Randomised traffic with random backpressure.
        repeat (400) begin
            cycle();
            out_ready = ($urandom_range(3) != 0);
            refresh(60);
        end
        drain();

        // Counter wrap after 65536 handshakes.
        do_reset();
        out_ready = 1'b1;
        refresh(100);
        done = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            cycle();
            if (hs_total >= 65536) begin
                done = 1'b1;
                break;
            end
            refresh(100);
        end
        out_ready = 1'b0;
        req_valid = req_valid & ~acc_last;
        @(negedge clk);
        chk("wrap_reached", 192'(done), 192'(1));
        chk("wrap_total", 192'(hs_total), 192'(65536));
        chk("wrap_cnt", 192'(done_cnt), 192'(0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort4_sched.md
# sort4_sched

Round-robin scheduler that shares one combinational 4-input ascending sorter (`sort4_net`) between `NREQ` requesters. Each requester offers a 4-word group over a valid/ready handshake. The block grants one group per cycle, registers it, sorts it, and presents the sorted group with the winning requester's ID on a single valid/ready output port. It sits in front of the median/sort datapath as its sequencer and arbiter.

## Interface
- `NREQ`, default 2: number of requesters, range 2..8.
- `ID_W`, default `$clog2(NREQ)`: width of the requester ID.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `req_valid` input, [NREQ]: requester i offers a group.
- `req_data` input, [NREQ][4] of `data_t` (32 bits): the group words; unsorted, unsigned.
- `req_ready` output, [NREQ]: requester i's group is accepted this cycle.
- `out_valid` output, 1 bit: a sorted group is presented.
- `out_ready` input, 1 bit: the consumer accepts the group.
- `out_data` output, [4] of `data_t`: the sorted group; `out_data[0]` ≤ … ≤ `out_data[3]`.
- `out_id` output, ID_W bits: index of the requester that sourced the group.
- `done_cnt` output, 16 bits: count of completed output handshakes; wraps at 65535 → 0.

## Operation
- **Pipeline:** two register stages.
  - S1 is the capture register: `s1_valid`, `s1_data[4]`, `s1_id`.
  - S2 is the output register: `out_valid`, `out_data`, `out_id`.
- **S2 load:** S2 loads `sort4_net(s1_data)` and `s1_id` when `s1_valid && (!out_valid || out_ready)`.
- **S1 free:** `s1_free = !s1_valid || (S2 loads this cycle)`.
- **Arbitration (combinational):**
  - The search starts at `(ptr+1) mod NREQ` and takes the first i with `req_valid[i]`.
  - `req_ready[i]` is high only for that i, and only when `s1_free`.
  - At most one `req_ready` bit is high per cycle.
- **Acceptance:** a group is accepted when `req_valid[i] && req_ready[i]`. On acceptance, S1 captures `req_data[i]` and i, and `ptr` is set to i.
- **Pointer hold:** `ptr` is unchanged in any cycle without an acceptance.
- **S1 clear:** `s1_valid` clears when S2 loads and nothing new is accepted.
- **Requester rule:** once `req_valid` is raised, the requester holds it and keeps `req_data` stable until `req_ready`. The block does not check this; the bench asserts it.
- **Output hold:** while `out_valid && !out_ready`, `out_data` and `out_id` hold. S1 then fills once and stalls, and all `req_ready` are low.
- **Counter:** `done_cnt` increments on every `out_valid && out_ready`.
- **Ordering:** `sort4_net` produces a non-decreasing order using unsigned compares. Equal keys are indistinguishable, so stability is irrelevant.
- **Reset values** (asynchronous, `rst_n` low):
  - `s1_valid`, `out_valid` = 0.
  - `out_data` = all 0; `out_id` = 0; `done_cnt` = 0.
  - `ptr` = NREQ-1, so requester 0 has first priority.
  - `req_ready` = 0 while in reset.
- **Reset mid-operation:** groups in flight in S1 and S2 are discarded without an output handshake.

## Timing
- **Latency:** a group accepted at edge k appears with `out_valid`=1 after edge k+1, provided S2 is free.
- **Throughput:** one group per cycle with `out_ready` tied high.
- **Combinational paths:**
  - `req_ready` depends combinationally on `req_valid`, `out_valid` and `out_ready`.
  - `out_*` are pure register outputs; there is no combinational input-to-output path.
- **Simultaneous events:**
  - S2 handshake, S1→S2 move and a new acceptance can all occur at the same edge with no bubble.
  - All requesters valid with `out_ready`=1 gives strict rotation 0,1,…,NREQ-1,0.
- **Reset release:** the first acceptance is possible at the first rising edge after `rst_n` deasserts.

## Structure
- **Shared package `sort_pkg`:** `typedef logic [31:0] data_t`, `localparam int SORT_N = 4`, `typedef data_t group_t [SORT_N]`.
- **Sub-module `sort4_net`:** purely combinational 4-word ascending sorter with 5 compare-exchanges in 3 levels: (0,1)(2,3), (0,2)(1,3), (1,2). It is instantiated once, between S1 and S2.
- **Top level:** the arbiter, pointer, the S1/S2 registers and the counter live in `sort4_sched`.

## Test plan
- **Single group:** requester 0 offers {9,3,7,1}, `out_ready`=1 → `req_ready[0]` high in the same cycle. Two edges later `out_data`={1,3,7,9}, `out_id`=0, `done_cnt`=1.
- **Fairness:** both requesters continuously valid for 6 groups, `out_ready`=1 → `out_id` sequence 0,1,0,1,0,1. One group per cycle after the first output.
- **Backpressure:** hold `out_ready`=0 for 5 cycles with both requesters valid → exactly 2 groups accepted. After that all `req_ready`=0, and `out_data` is stable. Releasing `out_ready` drains in order with no loss.
- **Duplicates and extremes:** {0xFFFFFFFF,0,0xFFFFFFFF,0} → {0,0,0xFFFFFFFF,0xFFFFFFFF}. Already-sorted {5,5,6,7} is unchanged.
- **Reset mid-flight:** assert `rst_n`=0 asynchronously with S1 and S2 both full → `out_valid`=0, `out_data`=0 and `done_cnt`=0 immediately. After release, requester 0 wins a simultaneous request.
- **Counter wrap:** force 65536 handshakes → `done_cnt` returns to 0.
